// File: rtl/kpn_pkg.sv
// Shared constants and types for the KPN channel reader.
package kpn_pkg;

    localparam int unsigned KPN_BITS_NUMBER = 16;
    localparam int unsigned KPN_COUNT_W     = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } kpn_rd_state_e;

endpackage

// File: rtl/kpn_channel_reader_if.sv
// Queue read port plus downstream valid/ready token port of the channel reader.
interface kpn_channel_reader_if #(
    parameter int unsigned BITS_NUMBER = kpn_pkg::KPN_BITS_NUMBER
);

    logic                   q_empty;
    logic [BITS_NUMBER-1:0] q_data;
    logic                   q_rd;
    logic                   out_valid;
    logic [BITS_NUMBER-1:0] out_data;
    logic                   out_ready;

    // master: the reader; slave: queue plus consuming process node
    modport master (
        input  q_empty, q_data, out_ready,
        output q_rd, out_valid, out_data
    );

    modport slave (
        output q_empty, q_data, out_ready,
        input  q_rd, out_valid, out_data
    );

endinterface

// File: rtl/kpn_skid_buffer.sv
// Two-entry FIFO skid buffer with EMPTY/ONE/FULL occupancy state machine.
module kpn_skid_buffer
    import kpn_pkg::*;
#(
    parameter int unsigned W = KPN_BITS_NUMBER
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         full
);

    kpn_rd_state_e state_q, state_d;
    logic [W-1:0]  head_q, head_d;
    logic [W-1:0]  tail_q, tail_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            full_q  <= full_d;
        end
    end

    // head always holds the oldest token; it keeps its value once drained
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pop     = valid_q & pop_ready;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        valid_d = (state_d != EMPTY);
        full_d  = (state_d == FULL);
    end

    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign full      = full_q;

endmodule

// File: rtl/kpn_channel_reader.sv
// KPN channel consumer front end: gated queue pops into a 2-entry skid buffer.
// Optional delivered-token counter enabled by defining KPN_READER_COUNT_EN.
module kpn_channel_reader
    import kpn_pkg::*;
#(
    parameter int unsigned BITS_NUMBER = KPN_BITS_NUMBER
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
`ifdef KPN_READER_COUNT_EN
    output logic [KPN_COUNT_W-1:0] token_count,
`endif
    kpn_channel_reader_if.master   bus
);

    logic                   sb_valid;
    logic [BITS_NUMBER-1:0] sb_data;
    logic                   sb_full;

    // registered empty flag makes this gate sufficient to prevent over-read
    assign bus.q_rd = ~reset & enable & ~bus.q_empty & ~sb_full;

    kpn_skid_buffer #(
        .W(BITS_NUMBER)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.q_rd),
        .push_data(bus.q_data),
        .pop_ready(bus.out_ready),
        .out_valid(sb_valid),
        .out_data (sb_data),
        .full     (sb_full)
    );

    assign bus.out_valid = sb_valid;
    assign bus.out_data  = sb_data;

`ifdef KPN_READER_COUNT_EN
    logic [KPN_COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (sb_valid && bus.out_ready) begin
            count_d = count_q + KPN_COUNT_W'(1);
        end
    end

    assign token_count = count_q;
`endif

endmodule

// File: tb/tb_kpn_channel_reader.sv
// Randomized and directed bench for kpn_channel_reader against a queue-level model.
module tb_kpn_channel_reader;
    import kpn_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    kpn_channel_reader_if #(.BITS_NUMBER(W)) bus ();

`ifdef KPN_READER_COUNT_EN
    logic [31:0] token_count;
`endif

    kpn_channel_reader #(.BITS_NUMBER(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
`ifdef KPN_READER_COUNT_EN
        .token_count(token_count),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference: channel queue contents, buffered tokens, last shown token
    logic [W-1:0] srcq[$];
    logic [W-1:0] mbuf[$];
    logic [W-1:0] got[$];
    logic [W-1:0] last_out;
    logic [31:0]  mcount;
    int           rd_seen;
    int           valid_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_q();
        bus.q_empty = (srcq.size() == 0);
        bus.q_data  = (srcq.size() != 0) ? srcq[0] : 16'hDEAD;
    endtask

    task automatic add_token(input logic [W-1:0] v);
        srcq.push_back(v);
        drive_q();
    endtask

    // one clock: check outputs mid-cycle, then advance the reference after the edge
    task automatic cycle();
        logic exp_rd;
        logic exp_valid;
        logic push;
        logic pop;
        @(negedge clk);
        exp_valid = (mbuf.size() != 0);
        exp_rd    = !reset && enable && (srcq.size() != 0) && (mbuf.size() < 2);
        check_eq("q_rd", 32'(bus.q_rd), 32'(exp_rd));
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check_eq("out_data", 32'(bus.out_data), 32'(exp_valid ? mbuf[0] : last_out));
`ifdef KPN_READER_COUNT_EN
        check_eq("token_count", token_count, mcount);
`endif
        if (bus.q_rd) rd_seen++;
        if (bus.out_valid) valid_seen++;
        if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        push = exp_rd;
        pop  = exp_valid && bus.out_ready;
        @(posedge clk);
        #1;
        if (reset) begin
            mbuf.delete();
            last_out = '0;
            mcount   = '0;
        end else begin
            if (pop) begin
                last_out = mbuf[0];
                void'(mbuf.pop_front());
                mcount = mcount + 32'd1;
            end
            if (push) begin
                mbuf.push_back(srcq[0]);
                void'(srcq.pop_front());
            end
        end
        drive_q();
    endtask

    task automatic check_got(input string tag, input logic [W-1:0] base, input int n);
        check_eq({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            check_eq(tag, 32'(got[i]), 32'(base + W'(i)));
        end
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        bus.out_ready = 1'b0;
        last_out      = '0;
        mcount        = '0;
        drive_q();
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;

        // back-to-back stream of four tokens
        for (int i = 1; i <= 4; i++) add_token(W'(i));
        enable = 1'b1; bus.out_ready = 1'b1;
        rd_seen = 0; got.delete();
        repeat (6) cycle();
        check_eq("t1_reads", 32'(rd_seen), 32'd4);
        check_got("t1_data", 16'h0001, 4);

        // back-pressure: only two pops, then drain in order
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) add_token(16'h0010 + W'(i));
        rd_seen = 0; got.delete();
        repeat (5) cycle();
        check_eq("t2_reads", 32'(rd_seen), 32'd2);
        check_eq("t2_state", 32'(dut.u_sb.state_q), 32'(FULL));
        bus.out_ready = 1'b1;
        repeat (6) cycle();
        check_got("t2_data", 16'h0010, 5);

        // empty queue never read
        rd_seen = 0; valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        check_eq("t3_reads", 32'(rd_seen), 32'd0);
        check_eq("t3_valid", 32'(valid_seen), 32'd0);

        // enable dropped while full: buffer drains, queue untouched
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) add_token(16'h0020 + W'(i));
        repeat (4) cycle();
        enable = 1'b0; bus.out_ready = 1'b1;
        rd_seen = 0; got.delete();
        repeat (5) cycle();
        check_eq("t4_reads", 32'(rd_seen), 32'd0);
        check_got("t4_drain", 16'h0020, 2);
        enable = 1'b1;
        repeat (6) cycle();
        check_got("t4_all", 16'h0020, 5);

        // reset while holding 0xBEEF with more data queued
        bus.out_ready = 1'b0;
        add_token(16'hBEEF);
        cycle();
        check_eq("t5_state", 32'(dut.u_sb.state_q), 32'(ONE));
        add_token(16'h1234);
        reset = 1'b1;
        cycle();
        reset = 1'b0; enable = 1'b0;
        cycle();
        check_eq("t5_state_rst", 32'(dut.u_sb.state_q), 32'(EMPTY));
        enable = 1'b1; bus.out_ready = 1'b1;
        got.delete();
        repeat (4) cycle();
        check_got("t5_after", 16'h1234, 1);

`ifdef KPN_READER_COUNT_EN
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) add_token(16'h0100 + W'(i));
        repeat (13) cycle();
        check_eq("t6_count10", token_count, 32'd10);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        mcount = 32'hFFFF_FFFF;
        add_token(16'h0200);
        repeat (3) cycle();
        check_eq("t6_wrap", token_count, 32'd0);
`endif

        // randomized traffic with occasional reset
        for (int n = 0; n < 2000; n++) begin
            if (srcq.size() < 8 && $urandom_range(0, 99) < 60) add_token(W'($urandom));
            enable        = ($urandom_range(0, 99) < 80);
            bus.out_ready = ($urandom_range(0, 99) < 60);
            reset         = ($urandom_range(0, 99) < 1);
            cycle();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
